// File: rtl/hsv_core_pkg.sv
// Shared core types for the ALU front end.
//   word      : 32-bit architectural datapath word
//   shift     : 6-bit right-shift amount (0..32)
//   adder_in  : 33-bit adder operand (bit 32 carries the borrow for compares)
//   alu_data_t: control forwarded alongside an ALU op
//   alu_op_t  : ALU operation encoding; codes above ALU_XOR are illegal
//   alu_issue_t / alu_setup_t: issued op and its decoded operand bundle
package hsv_core_pkg;

  typedef logic [31:0] word;
  typedef logic [5:0]  shift;
  typedef logic [32:0] adder_in;

  // Result selector for the shift/add substage.
  localparam logic [1:0] ALU_OUT_ADDER = 2'd0;
  localparam logic [1:0] ALU_OUT_SHIFT = 2'd1;

  typedef struct packed {
    logic [4:0] rd;
    logic [1:0] out_select;
    logic       compare;
    logic       illegal;
    logic       fetch_fault;
  } alu_data_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_SLL  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_AND  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_XOR  = 4'd9
  } alu_op_t;

  typedef struct packed {
    alu_op_t   op;
    word       src1;
    word       src2;
    alu_data_t data;
  } alu_issue_t;

  // Everything the output register (and the skid) holds for one op.
  typedef struct packed {
    alu_data_t data;
    word       shift_lo;
    word       shift_hi;
    shift      shift_count;
    adder_in   adder_a;
    adder_in   adder_b;
  } alu_setup_t;

  localparam word SIGN_BIT = 32'h8000_0000;

  // 33-bit two's complement of a zero-extended word: a + this = a - w,
  // and bit 32 of the sum is set exactly when a < w (unsigned).
  function automatic adder_in negate_operand(input word w);
    return 33'd0 - {1'b0, w};
  endfunction

endpackage

// File: rtl/hsv_core_alu_setup_if.sv
// Issue-side and downstream-side signals of the ALU setup substage.
// Handshake: an op transfers on a clock edge where valid_i & ready_o are both
// high; the issuer holds in_issue stable while valid_i is high and the op has
// not transferred. valid_o marks out_* as a meaningful op for the shift/add
// substage, which consumes it on every edge where stall is low.
//   master : issuer / pipeline control side (drives stall, flush, issue)
//   slave  : the setup substage
interface hsv_core_alu_setup_if
  import hsv_core_pkg::*;
;
  logic       stall;
  logic       flush_req;
  logic       valid_i;
  logic       ready_o;
  alu_issue_t in_issue;
  logic       valid_o;
  alu_data_t  out_alu_data;
  word        out_shift_lo;
  word        out_shift_hi;
  shift       out_shift_count;
  adder_in    out_adder_a;
  adder_in    out_adder_b;

  modport master (
    output stall, flush_req, valid_i, in_issue,
    input  ready_o, valid_o, out_alu_data, out_shift_lo, out_shift_hi,
           out_shift_count, out_adder_a, out_adder_b
  );

  modport slave (
    input  stall, flush_req, valid_i, in_issue,
    output ready_o, valid_o, out_alu_data, out_shift_lo, out_shift_hi,
           out_shift_count, out_adder_a, out_adder_b
  );

endinterface

// File: rtl/hsv_core_alu_setup_decode.sv
// Purely combinational operand mapping of one issued ALU op onto the shared
// right-shifter ({hi,lo} >> count) and 33-bit adder (a + b) operand format.
//   issue : issued op (op, src1, src2, forwarded control)
//   setup : decoded operands plus control with out_select/compare filled in
module hsv_core_alu_setup_decode
  import hsv_core_pkg::*;
(
  input  alu_issue_t issue,
  output alu_setup_t setup
);

  word        s1;
  word        s2;
  logic [4:0] n;

  assign s1 = issue.src1;
  assign s2 = issue.src2;
  assign n  = issue.src2[4:0];

  always_comb begin
    setup                 = '0;
    setup.data            = issue.data;
    setup.data.out_select = ALU_OUT_ADDER;
    setup.data.compare    = 1'b0;
    // Illegal ops (flagged or unknown encoding) keep all operands at zero.
    if (!issue.data.illegal) begin
      case (issue.op)
        ALU_ADD: begin
          setup.adder_a = {1'b0, s1};
          setup.adder_b = {1'b0, s2};
        end
        ALU_SUB: begin
          setup.adder_a = {1'b0, s1};
          setup.adder_b = negate_operand(s2);
        end
        ALU_SLTU: begin
          setup.adder_a      = {1'b0, s1};
          setup.adder_b      = negate_operand(s2);
          setup.data.compare = 1'b1;
        end
        ALU_SLT: begin
          // Flipping the sign bits turns a signed compare into an unsigned one.
          setup.adder_a      = {1'b0, s1 ^ SIGN_BIT};
          setup.adder_b      = negate_operand(s2 ^ SIGN_BIT);
          setup.data.compare = 1'b1;
        end
        ALU_SLL: begin
          // Left shift by n == right shift of {x,0} by 32-n; n=0 gives 32.
          setup.shift_hi        = s1;
          setup.shift_count     = 6'd32 - {1'b0, n};
          setup.data.out_select = ALU_OUT_SHIFT;
        end
        ALU_SRL: begin
          setup.shift_lo        = s1;
          setup.shift_count     = {1'b0, n};
          setup.data.out_select = ALU_OUT_SHIFT;
        end
        ALU_SRA: begin
          setup.shift_hi        = {32{s1[31]}};
          setup.shift_lo        = s1;
          setup.shift_count     = {1'b0, n};
          setup.data.out_select = ALU_OUT_SHIFT;
        end
        // Bitwise results ride through the shifter with a zero count.
        ALU_AND: begin
          setup.shift_lo        = s1 & s2;
          setup.data.out_select = ALU_OUT_SHIFT;
        end
        ALU_OR: begin
          setup.shift_lo        = s1 | s2;
          setup.data.out_select = ALU_OUT_SHIFT;
        end
        ALU_XOR: begin
          setup.shift_lo        = s1 ^ s2;
          setup.data.out_select = ALU_OUT_SHIFT;
        end
        default: begin
          setup.shift_lo = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hsv_core_alu_setup.sv
// ALU setup substage: accepts one ALU op per cycle, decodes it into
// shifter/adder operands and registers it for the shift/add substage.
// A one-entry skid buffer absorbs the op accepted in a stalled cycle so that
// ready_o depends only on registered state, flush_req and reset.
//   clk_core : core clock
//   rst_core : asynchronous active-high reset
//   bus      : issue/downstream handshake and operand outputs (slave side)
module hsv_core_alu_setup
  import hsv_core_pkg::*;
(
  input logic                  clk_core,
  input logic                  rst_core,
  hsv_core_alu_setup_if.slave  bus
);

  alu_setup_t dec;
  alu_setup_t skid_q;
  alu_setup_t out_q;
  logic       skid_valid;
  logic       out_valid;
  logic       ready;
  logic       fire;

  hsv_core_alu_setup_decode u_decode (
    .issue (bus.in_issue),
    .setup (dec)
  );

  // Skid is never loaded while full, so an occupied skid blocks new ops.
  assign ready = ~skid_valid & ~bus.flush_req & ~rst_core;
  assign fire  = bus.valid_i & ready;

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      out_q      <= '0;
      out_valid  <= 1'b0;
      skid_q     <= '0;
      skid_valid <= 1'b0;
    end else if (bus.flush_req) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!bus.stall) begin
      if (skid_valid) begin
        out_q     <= skid_q;
        out_valid <= 1'b1;
      end else if (fire) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
      skid_valid <= 1'b0;
    end else if (fire) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign bus.ready_o         = ready;
  assign bus.valid_o         = out_valid;
  assign bus.out_alu_data    = out_q.data;
  assign bus.out_shift_lo    = out_q.shift_lo;
  assign bus.out_shift_hi    = out_q.shift_hi;
  assign bus.out_shift_count = out_q.shift_count;
  assign bus.out_adder_a     = out_q.adder_a;
  assign bus.out_adder_b     = out_q.adder_b;

endmodule

// File: tb/tb_hsv_core_alu_setup.sv
module tb_hsv_core_alu_setup;
  import hsv_core_pkg::*;

  // Architectural expectation for one op: the result the shift/add stage
  // must produce, the forwarded control, and whether operands must be zero.
  typedef struct packed {
    word       result;
    alu_data_t data;
    logic      zero_ops;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk_core = 1'b0;
  logic rst_core = 1'b1;
  always #5 clk_core = ~clk_core;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  hsv_core_alu_setup_if bus ();

  hsv_core_alu_setup dut (
    .clk_core (clk_core),
    .rst_core (rst_core),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t model_op(input alu_issue_t t);
    exp_t       e;
    logic [4:0] n;
    logic [3:0] opc;
    n                 = t.src2[4:0];
    opc               = t.op;
    e.result          = '0;
    e.data            = t.data;
    e.data.compare    = 1'b0;
    e.data.out_select = ALU_OUT_ADDER;
    e.zero_ops        = 1'b0;
    if (t.data.illegal || opc > 4'd9) begin
      e.zero_ops = 1'b1;
    end else begin
      case (t.op)
        ALU_ADD:  e.result = t.src1 + t.src2;
        ALU_SUB:  e.result = t.src1 - t.src2;
        ALU_SLT:  begin
          e.result       = ($signed(t.src1) < $signed(t.src2)) ? 32'd1 : 32'd0;
          e.data.compare = 1'b1;
        end
        ALU_SLTU: begin
          e.result       = (t.src1 < t.src2) ? 32'd1 : 32'd0;
          e.data.compare = 1'b1;
        end
        ALU_SLL:  begin e.result = t.src1 << n; e.data.out_select = ALU_OUT_SHIFT; end
        ALU_SRL:  begin e.result = t.src1 >> n; e.data.out_select = ALU_OUT_SHIFT; end
        ALU_SRA:  begin e.result = word'($signed(t.src1) >>> n); e.data.out_select = ALU_OUT_SHIFT; end
        ALU_AND:  begin e.result = t.src1 & t.src2; e.data.out_select = ALU_OUT_SHIFT; end
        ALU_OR:   begin e.result = t.src1 | t.src2; e.data.out_select = ALU_OUT_SHIFT; end
        ALU_XOR:  begin e.result = t.src1 ^ t.src2; e.data.out_select = ALU_OUT_SHIFT; end
        default:  e.result = '0;
      endcase
    end
    return e;
  endfunction

  // What the downstream shift/add stage computes from the setup outputs.
  function automatic word downstream(input alu_data_t d, input word lo, input word hi,
                                     input shift cnt, input adder_in a, input adder_in b);
    logic [63:0] wide;
    adder_in     sum;
    if (d.out_select == ALU_OUT_SHIFT) begin
      wide = {hi, lo} >> cnt;
      return wide[31:0];
    end
    sum = a + b;
    return d.compare ? {31'd0, sum[32]} : sum[31:0];
  endfunction

  // Scoreboard: exp_q holds accepted ops in order; the head is on the
  // output when m_out_valid is set, anything behind it is waiting.
  logic [EXP_W-1:0] exp_q[$];
  logic             m_out_valid = 1'b0;
  logic             m_fire      = 1'b0;

  function automatic logic model_ready();
    return (exp_q.size() == (m_out_valid ? 1 : 0)) && !bus.flush_req && !rst_core;
  endfunction

  always @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      exp_q.delete();
      m_out_valid = 1'b0;
      m_fire      = 1'b0;
    end else begin
      m_fire = bus.valid_i && model_ready();
      if (bus.flush_req) begin
        exp_q.delete();
        m_out_valid = 1'b0;
      end else if (!bus.stall) begin
        if (m_out_valid) void'(exp_q.pop_front());
        if (m_fire) exp_q.push_back(model_op(bus.in_issue));
        m_out_valid = (exp_q.size() > 0);
      end else if (m_fire) begin
        exp_q.push_back(model_op(bus.in_issue));
      end
    end
  end

  // ---------------- compare process ----------------
  logic       log_en = 1'b0;
  logic [4:0] seen_rd[$];

  always @(negedge clk_core) begin
    exp_t e;
    chk("ready_o", bus.ready_o, model_ready());
    chk("valid_o", bus.valid_o, m_out_valid);
    if (m_out_valid && bus.valid_o && exp_q.size() > 0) begin
      e = exp_t'(exp_q[0]);
      chk("out_alu_data", bus.out_alu_data, e.data);
      chk("result", downstream(bus.out_alu_data, bus.out_shift_lo, bus.out_shift_hi,
                               bus.out_shift_count, bus.out_adder_a, bus.out_adder_b), e.result);
      chk("count_range", bus.out_shift_count <= 6'd32, 1'b1);
      if (e.zero_ops)
        chk("zero_ops", |{bus.out_shift_lo, bus.out_shift_hi, bus.out_shift_count,
                          bus.out_adder_a, bus.out_adder_b}, 1'b0);
      if (log_en && !bus.stall) seen_rd.push_back(bus.out_alu_data.rd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic idle();
    bus.valid_i   = 1'b0;
    bus.stall     = 1'b0;
    bus.flush_req = 1'b0;
    bus.in_issue  = '0;
  endtask

  function automatic alu_issue_t mk(input alu_op_t op, input word s1, input word s2,
                                    input logic [4:0] rd);
    alu_issue_t t;
    t         = '0;
    t.op      = op;
    t.src1    = s1;
    t.src2    = s2;
    t.data.rd = rd;
    return t;
  endfunction

  // Offer one op for a single cycle; returns just after it has been registered.
  task automatic issue_one(input alu_issue_t t);
    bus.valid_i  = 1'b1;
    bus.in_issue = t;
    step();
    bus.valid_i  = 1'b0;
  endtask

  function automatic word rand_word();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return word'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  function automatic alu_issue_t rand_issue();
    alu_issue_t t;
    int         r;
    r                  = $urandom_range(0, 19);
    t.op               = alu_op_t'(4'((r < 18) ? (r % 10) : (r - 8)));
    t.src1             = rand_word();
    t.src2             = rand_word();
    t.data             = '0;
    t.data.rd          = 5'($urandom_range(0, 31));
    t.data.illegal     = ($urandom_range(0, 15) == 0);
    t.data.fetch_fault = ($urandom_range(0, 7) == 0);
    t.data.out_select  = 2'($urandom_range(0, 3));
    t.data.compare     = 1'($urandom_range(0, 1));
    return t;
  endfunction

  // ---------------- stimulus ----------------
  alu_issue_t op_a, op_b, op_c;

  initial begin
    idle();
    repeat (2) @(posedge clk_core);
    #1;
    chk("reset_valid", bus.valid_o, 1'b0);
    chk("reset_ready", bus.ready_o, 1'b0);
    chk("reset_data", |{bus.out_alu_data, bus.out_shift_lo, bus.out_shift_hi,
                        bus.out_shift_count, bus.out_adder_a, bus.out_adder_b}, 1'b0);
    rst_core = 1'b0;
    #1;
    chk("ready_after_reset", bus.ready_o, 1'b1);
    step();

    // Hand-computed vectors
    issue_one(mk(ALU_SUB, 32'd5, 32'd7, 5'd1));
    chk("sub_a", bus.out_adder_a, 33'h0_0000_0005);
    chk("sub_b", bus.out_adder_b, 33'h1_FFFF_FFF9);
    chk("sub_res", downstream(bus.out_alu_data, bus.out_shift_lo, bus.out_shift_hi,
        bus.out_shift_count, bus.out_adder_a, bus.out_adder_b), 32'hFFFF_FFFE);

    issue_one(mk(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd2));
    chk("slt_cmp", bus.out_alu_data.compare, 1'b1);
    chk("slt_a", bus.out_adder_a, 33'h0_7FFF_FFFF);
    chk("slt_b", bus.out_adder_b, 33'h1_7FFF_FFFF);
    chk("slt_res", downstream(bus.out_alu_data, bus.out_shift_lo, bus.out_shift_hi,
        bus.out_shift_count, bus.out_adder_a, bus.out_adder_b), 32'd1);

    issue_one(mk(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd3));
    chk("sltu_res", downstream(bus.out_alu_data, bus.out_shift_lo, bus.out_shift_hi,
        bus.out_shift_count, bus.out_adder_a, bus.out_adder_b), 32'd0);

    issue_one(mk(ALU_SLL, 32'h1234_5678, 32'd0, 5'd4));
    chk("sll0_count", bus.out_shift_count, 6'd32);
    chk("sll0_hi", bus.out_shift_hi, 32'h1234_5678);

    issue_one(mk(ALU_SLL, 32'h1234_5678, 32'd31, 5'd5));
    chk("sll31_count", bus.out_shift_count, 6'd1);

    issue_one(mk(ALU_SRA, 32'h8000_0000, 32'd4, 5'd6));
    chk("sra_hi", bus.out_shift_hi, 32'hFFFF_FFFF);
    chk("sra_res", downstream(bus.out_alu_data, bus.out_shift_lo, bus.out_shift_hi,
        bus.out_shift_count, bus.out_adder_a, bus.out_adder_b), 32'hF800_0000);

    issue_one(mk(ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7));
    chk("xor_lo", bus.out_shift_lo, 32'h0FF0_0FF0);
    chk("xor_count", bus.out_shift_count, 6'd0);
    step();

    // Stall + skid: A, B, C with stall high for three cycles starting at B
    op_a = mk(ALU_ADD, 32'd1, 32'd2, 5'd11);
    op_b = mk(ALU_SUB, 32'd9, 32'd4, 5'd12);
    op_c = mk(ALU_OR, 32'h00F0, 32'h0F00, 5'd13);
    seen_rd.delete();
    log_en       = 1'b1;
    bus.valid_i  = 1'b1;
    bus.in_issue = op_a;
    step();
    bus.in_issue = op_b;
    bus.stall    = 1'b1;
    step();
    chk("stall_ready_low", bus.ready_o, 1'b0);
    bus.in_issue = op_c;
    step();
    step();
    bus.stall = 1'b0;
    step();
    chk("stall_ready_back", bus.ready_o, 1'b1);
    step();
    bus.valid_i = 1'b0;
    repeat (3) step();
    log_en = 1'b0;
    chk("order_len", seen_rd.size(), 3);
    if (seen_rd.size() == 3) begin
      chk("order_0", seen_rd[0], 5'd11);
      chk("order_1", seen_rd[1], 5'd12);
      chk("order_2", seen_rd[2], 5'd13);
    end

    // Flush with both entries full and stall high
    bus.valid_i  = 1'b1;
    bus.in_issue = op_a;
    step();
    bus.in_issue = op_b;
    bus.stall    = 1'b1;
    step();
    chk("flush_pre_valid", bus.valid_o, 1'b1);
    chk("flush_pre_ready", bus.ready_o, 1'b0);
    bus.valid_i   = 1'b0;
    bus.flush_req = 1'b1;
    step();
    bus.flush_req = 1'b0;
    #1;
    chk("flush_valid", bus.valid_o, 1'b0);
    chk("flush_ready", bus.ready_o, 1'b1);
    bus.stall = 1'b0;
    step();

    // Randomized traffic; an offered op is held until it is accepted
    for (int i = 0; i < 2500; i++) begin
      if (!bus.valid_i || m_fire) begin
        if ($urandom_range(0, 9) < 7) begin
          bus.valid_i  = 1'b1;
          bus.in_issue = rand_issue();
        end else begin
          bus.valid_i = 1'b0;
        end
      end
      bus.stall     = ($urandom_range(0, 9) < 3);
      bus.flush_req = ($urandom_range(0, 31) == 0);
      step();
    end
    idle();
    step();

    // Reset asserted mid-cycle with both entries full
    bus.valid_i  = 1'b1;
    bus.in_issue = op_c;
    step();
    bus.in_issue = op_a;
    bus.stall    = 1'b1;
    step();
    bus.valid_i = 1'b0;
    #2;
    rst_core = 1'b1;
    #1;
    chk("rst_mid_valid", bus.valid_o, 1'b0);
    chk("rst_mid_ready", bus.ready_o, 1'b0);
    chk("rst_mid_data", |{bus.out_alu_data, bus.out_shift_lo, bus.out_shift_hi,
                          bus.out_shift_count, bus.out_adder_a, bus.out_adder_b}, 1'b0);
    idle();
    step();
    rst_core = 1'b0;
    step();
    issue_one(mk(ALU_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd20));
    chk("post_rst_and", bus.out_shift_lo, 32'h0F0F_0000);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
